// File: rtl/sd_cmd_tx.sv
// SD CMD-line host command transmitter: serializes start/tx/index/arg/CRC7/end
// one bit per sd_ce strobe, then holds the line released for NCC strobes.
//
// state   | meaning
// IDLE    | ready for a command, line released
// ARMED   | command latched, waiting for the first strobe
// CONTENT | driving the 40 content bits, CRC accumulating
// CRCOUT  | driving the 7 CRC bits from a shift copy
// ENDBIT  | driving the end bit
// GAP     | line released, counting NCC idle strobes
module sd_cmd_tx #(
  parameter int NCC = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_ce,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        done,
  output logic [6:0]  crc
);

  localparam int GW = $clog2(NCC + 1);

  typedef enum logic [2:0] {IDLE, ARMED, CONTENT, CRCOUT, ENDBIT, GAP} state_t;

  state_t        state, state_nx;
  logic [39:0]   shreg, shreg_nx;
  logic [6:0]    crc_nx, crc_sh, crc_sh_nx, crc_step;
  logic [5:0]    bitcnt, bitcnt_nx;
  logic [GW-1:0] gapcnt, gapcnt_nx;
  logic          out_nx, oe_nx, ready_nx, done_nx;
  logic          fb;

  assign fb       = crc[6] ^ shreg[39];
  assign crc_step = {crc[5:3], crc[2] ^ fb, crc[1:0], fb};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      crc       <= '0;
      crc_sh    <= '0;
      bitcnt    <= '0;
      gapcnt    <= '0;
      cmd_out   <= 1'b1;
      cmd_oe    <= 1'b0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      crc       <= crc_nx;
      crc_sh    <= crc_sh_nx;
      bitcnt    <= bitcnt_nx;
      gapcnt    <= gapcnt_nx;
      cmd_out   <= out_nx;
      cmd_oe    <= oe_nx;
      cmd_ready <= ready_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    crc_nx    = crc;
    crc_sh_nx = crc_sh;
    bitcnt_nx = bitcnt;
    gapcnt_nx = gapcnt;
    out_nx    = cmd_out;
    oe_nx     = cmd_oe;
    ready_nx  = cmd_ready;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          shreg_nx = {2'b01, cmd_index, cmd_arg};
          crc_nx   = '0;
          ready_nx = 1'b0;
          state_nx = ARMED;
        end
      end
      ARMED, CONTENT: begin
        if (sd_ce) begin
          out_nx    = shreg[39];
          oe_nx     = 1'b1;
          crc_nx    = crc_step;
          shreg_nx  = {shreg[38:0], 1'b0};
          bitcnt_nx = (state == ARMED) ? 6'd1 : bitcnt + 6'd1;
          state_nx  = CONTENT;
          // 40th bit: snapshot the final CRC so crc itself can stay frozen
          if (state == CONTENT && bitcnt == 6'd39) begin
            crc_sh_nx = crc_step;
            bitcnt_nx = '0;
            state_nx  = CRCOUT;
          end
        end
      end
      CRCOUT: begin
        if (sd_ce) begin
          out_nx    = crc_sh[6];
          crc_sh_nx = {crc_sh[5:0], 1'b0};
          bitcnt_nx = bitcnt + 6'd1;
          if (bitcnt == 6'd6) state_nx = ENDBIT;
        end
      end
      ENDBIT: begin
        if (sd_ce) begin
          out_nx    = 1'b1;
          gapcnt_nx = '0;
          state_nx  = GAP;
        end
      end
      GAP: begin
        if (sd_ce) begin
          oe_nx  = 1'b0;
          out_nx = 1'b1;
          if (gapcnt == GW'(NCC - 1)) begin
            done_nx  = 1'b1;
            ready_nx = 1'b1;
            state_nx = IDLE;
          end else begin
            gapcnt_nx = gapcnt + GW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
